// File: rtl/unary_to_binary_collector_if.sv
// Handshake/bus bundle between the unary adder side, the collector and the
// downstream consumer of the recovered binary sum.
interface unary_to_binary_collector_if #(
   parameter int unsigned W = 15
);
   logic         en;
   logic         read_or_write;
   logic         din;
   logic         carry_in;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         overflow;
   logic         result_valid;
   logic         overrun;
   logic         busy;

   modport master (
      output en, read_or_write, din, carry_in, out_ready,
      input  result, carry, overflow, result_valid, overrun, busy
   );

   modport slave (
      input  en, read_or_write, din, carry_in, out_ready,
      output result, carry, overflow, result_valid, overrun, busy
   );
endinterface

// File: rtl/unary_to_binary_collector.sv
// Counts the unary adder's write-phase pulse train back into a binary sum and
// hands sum, carry and overflow status downstream via valid/ready.
module unary_to_binary_collector #(
   parameter int unsigned W = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   unary_to_binary_collector_if.slave    io_bus
);

   localparam logic [W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_COLLECT = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t       r_state,    w_state_nxt;
   logic [W-1:0] r_cnt,      w_cnt_nxt;
   logic         r_carry_lat, w_carry_lat_nxt;
   logic         r_ovf_lat,  w_ovf_lat_nxt;
   logic         r_prev_rw,  w_prev_rw_nxt;
   logic [W-1:0] r_result,   w_result_nxt;
   logic         r_carry,    w_carry_nxt;
   logic         r_overflow, w_overflow_nxt;
   logic         r_valid,    w_valid_nxt;
   logic         r_overrun,  w_overrun_nxt;
   logic         r_busy,     w_busy_nxt;
   logic         w_phase_start;

   // A write phase begins on the first enabled cycle with read_or_write high.
   assign w_phase_start = io_bus.en & io_bus.read_or_write & ~r_prev_rw;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_carry_lat <= 1'b0;
         r_ovf_lat   <= 1'b0;
         r_prev_rw   <= 1'b0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_carry_lat <= w_carry_lat_nxt;
         r_ovf_lat   <= w_ovf_lat_nxt;
         r_prev_rw   <= w_prev_rw_nxt;
         r_result    <= w_result_nxt;
         r_carry     <= w_carry_nxt;
         r_overflow  <= w_overflow_nxt;
         r_valid     <= w_valid_nxt;
         r_overrun   <= w_overrun_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_carry_lat_nxt = r_carry_lat;
      w_ovf_lat_nxt   = r_ovf_lat;
      w_prev_rw_nxt   = r_prev_rw;
      w_result_nxt    = r_result;
      w_carry_nxt     = r_carry;
      w_overflow_nxt  = r_overflow;
      w_valid_nxt     = r_valid;
      w_overrun_nxt   = r_overrun;

      if (io_bus.en) begin
         w_prev_rw_nxt = io_bus.read_or_write;
      end

      unique case (r_state)
         S_IDLE: begin
            if (io_bus.en && io_bus.carry_in) begin
               w_carry_lat_nxt = 1'b1;
            end
            if (w_phase_start) begin
               w_state_nxt = S_ARM;
               w_cnt_nxt   = '0;
            end
         end

         // din still shows the adder's read-phase value here; only carry counts.
         S_ARM: begin
            if (io_bus.en) begin
               if (io_bus.carry_in) begin
                  w_carry_lat_nxt = 1'b1;
               end
               w_state_nxt = S_COLLECT;
            end
         end

         S_COLLECT: begin
            if (io_bus.en) begin
               if (io_bus.read_or_write && io_bus.din) begin
                  if (r_cnt == CNT_MAX) begin
                     w_ovf_lat_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + W'(1);
                  end
               end else begin
                  // End of train, either natural (din low) or truncated (phase dropped).
                  w_result_nxt   = r_cnt;
                  w_carry_nxt    = r_carry_lat;
                  w_overflow_nxt = r_ovf_lat;
                  w_valid_nxt    = 1'b1;
                  w_state_nxt    = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (io_bus.out_ready) begin
               w_valid_nxt     = 1'b0;
               w_carry_lat_nxt = 1'b0;
               w_ovf_lat_nxt   = 1'b0;
               if (w_phase_start) begin
                  w_state_nxt = S_ARM;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (w_phase_start) begin
               w_overrun_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_COLLECT);
   end

   assign io_bus.result       = r_result;
   assign io_bus.carry        = r_carry;
   assign io_bus.overflow     = r_overflow;
   assign io_bus.result_valid = r_valid;
   assign io_bus.overrun      = r_overrun;
   assign io_bus.busy         = r_busy;

endmodule

// File: tb/tb_unary_to_binary_collector.sv
// Directed bench for unary_to_binary_collector: a W=15 and a W=4 instance share
// one stimulus stream; each scenario task checks hand-computed results.
module tb_unary_to_binary_collector;

   logic clk = 1'b0;
   logic rst;
   logic en, rw, din, cin, rdy;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   unary_to_binary_collector_if #(.W(15)) bus15 ();
   unary_to_binary_collector_if #(.W(4))  bus4 ();

   assign bus15.en = en;  assign bus15.read_or_write = rw;  assign bus15.din = din;
   assign bus15.carry_in = cin;  assign bus15.out_ready = rdy;
   assign bus4.en  = en;  assign bus4.read_or_write  = rw;  assign bus4.din  = din;
   assign bus4.carry_in  = cin;  assign bus4.out_ready  = rdy;

   unary_to_binary_collector #(.W(15)) dut15 (.clk(clk), .rst(rst), .io_bus(bus15));
   unary_to_binary_collector #(.W(4))  dut4  (.clk(clk), .rst(rst), .io_bus(bus4));

   // Drive one cycle of stimulus and return 1 time unit after the edge.
   task automatic cyc(input logic e, input logic r, input logic d, input logic c);
      en = e; rw = r; din = d; cin = c;
      @(posedge clk);
      #1;
   endtask

   // Read cycle, phase-start cycle, then the ARM cycle (carry visible there).
   task automatic start_phase(input logic c_arm);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, c_arm);
   endtask

   task automatic ones(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      n_tests++;
      if ({bus15.result, bus15.carry, bus15.overflow, bus15.result_valid, bus15.overrun, bus15.busy} !== 20'd0) begin
         n_fail++; $display("FAIL reset_w15: got %h expected 0",
            {bus15.result, bus15.carry, bus15.overflow, bus15.result_valid, bus15.overrun, bus15.busy});
      end
      n_tests++;
      if ({bus4.result, bus4.carry, bus4.overflow, bus4.result_valid, bus4.overrun, bus4.busy} !== 9'd0) begin
         n_fail++; $display("FAIL reset_w4: got %h expected 0",
            {bus4.result, bus4.carry, bus4.overflow, bus4.result_valid, bus4.overrun, bus4.busy});
      end
   endtask

   task automatic test_basic();
      rdy = 1'b1;
      start_phase(1'b0);
      n_tests++;
      if (bus15.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus15.busy); end
      ones(5);
      n_tests++;
      if (bus15.result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", bus15.result_valid); end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (bus15.result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_at7: got %b expected 1", bus15.result_valid); end
      n_tests++;
      if ({bus15.result, bus15.carry, bus15.overflow} !== {15'd5, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL basic_result: got %0d c%b o%b expected 5 c0 o0", bus15.result, bus15.carry, bus15.overflow);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.busy} !== 2'b00) begin
         n_fail++; $display("FAIL basic_accept: got valid%b busy%b expected 0 0", bus15.result_valid, bus15.busy);
      end
      n_tests++;
      if (bus15.result !== 15'd5) begin n_fail++; $display("FAIL basic_result_hold: got %0d expected 5", bus15.result); end
   endtask

   task automatic test_zero();
      rdy = 1'b1;
      start_phase(1'b0);
      n_tests++;
      if (bus15.result_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_early: got %b expected 0", bus15.result_valid); end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.result} !== {1'b1, 15'd0}) begin
         n_fail++; $display("FAIL zero_result: got valid%b %0d expected valid1 0", bus15.result_valid, bus15.result);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_carry();
      rdy = 1'b1;
      start_phase(1'b1);
      ones(3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.result, bus15.carry} !== {1'b1, 15'd3, 1'b1}) begin
         n_fail++; $display("FAIL carry_set: got valid%b %0d c%b expected valid1 3 c1", bus15.result_valid, bus15.result, bus15.carry);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      start_phase(1'b0);
      ones(1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.result, bus15.carry} !== {1'b1, 15'd1, 1'b0}) begin
         n_fail++; $display("FAIL carry_clear: got valid%b %0d c%b expected valid1 1 c0", bus15.result_valid, bus15.result, bus15.carry);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      rdy = 1'b1;
      start_phase(1'b0);
      ones(20);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus4.result_valid, bus4.result, bus4.overflow} !== {1'b1, 4'd15, 1'b1}) begin
         n_fail++; $display("FAIL ovf_w4: got valid%b %0d o%b expected valid1 15 o1", bus4.result_valid, bus4.result, bus4.overflow);
      end
      n_tests++;
      if ({bus15.result, bus15.overflow} !== {15'd20, 1'b0}) begin
         n_fail++; $display("FAIL ovf_w15: got %0d o%b expected 20 o0", bus15.result, bus15.overflow);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      start_phase(1'b0);
      ones(2);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus4.result, bus4.overflow} !== {4'd2, 1'b0}) begin
         n_fail++; $display("FAIL ovf_w4_cleared: got %0d o%b expected 2 o0", bus4.result, bus4.overflow);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_overrun();
      rdy = 1'b0;
      start_phase(1'b0);
      ones(5);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (bus15.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b expected 0", bus15.overrun); end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.overrun, bus15.result_valid, bus15.result} !== {1'b1, 1'b1, 15'd5}) begin
         n_fail++; $display("FAIL overrun_set: got ovr%b valid%b %0d expected ovr1 valid1 5", bus15.overrun, bus15.result_valid, bus15.result);
      end
      ones(3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result, bus15.result_valid, bus15.busy} !== {15'd5, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL overrun_held: got %0d valid%b busy%b expected 5 valid1 busy0", bus15.result, bus15.result_valid, bus15.busy);
      end
      rdy = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      start_phase(1'b0);
      ones(2);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.result, bus15.overrun} !== {1'b1, 15'd2, 1'b1}) begin
         n_fail++; $display("FAIL overrun_recover: got valid%b %0d ovr%b expected valid1 2 ovr1", bus15.result_valid, bus15.result, bus15.overrun);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_en_gating();
      rdy = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         cyc(1'b1, 1'b1, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.busy} !== 2'b01) begin
         n_fail++; $display("FAIL en_frozen: got valid%b busy%b expected valid0 busy1", bus15.result_valid, bus15.busy);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.result} !== {1'b1, 15'd4}) begin
         n_fail++; $display("FAIL en_result: got valid%b %0d expected valid1 4", bus15.result_valid, bus15.result);
      end
      rdy = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (bus15.result_valid !== 1'b0) begin n_fail++; $display("FAIL en_accept_when_disabled: got %b expected 0", bus15.result_valid); end
   endtask

   task automatic test_reset_mid();
      rdy = 1'b1;
      start_phase(1'b0);
      ones(3);
      n_tests++;
      if (bus15.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 1", bus15.busy); end
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      n_tests++;
      if ({bus15.result, bus15.carry, bus15.overflow, bus15.result_valid, bus15.overrun, bus15.busy} !== 20'd0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0",
            {bus15.result, bus15.carry, bus15.overflow, bus15.result_valid, bus15.overrun, bus15.busy});
      end
      start_phase(1'b0);
      ones(2);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({bus15.result_valid, bus15.result, bus15.carry, bus15.overflow} !== {1'b1, 15'd2, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rst_mid_after: got valid%b %0d c%b o%b expected valid1 2 c0 o0",
            bus15.result_valid, bus15.result, bus15.carry, bus15.overflow);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rw = 1'b0; din = 1'b0; cin = 1'b0; rdy = 1'b0;
      test_reset();
      test_basic();
      test_zero();
      test_carry();
      test_overflow();
      test_overrun();
      test_en_gating();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
